// File: rtl/issue_frontend.sv
// In-order issue front end: instruction FIFO plus a register alias table that tracks producer tags.
// Optional ISSUE_STALL_CNT_EN macro adds a saturating hazard-stall counter on the stall_cycles port.
module issue_frontend #(
   parameter int TAG_WIDTH = 4,
   parameter int IQ_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fetch_valid,
   input  logic [2:0]           fetch_op,
   input  logic [4:0]           fetch_rs1,
   input  logic [4:0]           fetch_rs2,
   input  logic [4:0]           fetch_rd,
   input  logic [31:0]          fetch_pc,
   output logic                 fetch_ready,
   output logic                 inst_valid,
   output logic [2:0]           inst_op,
   output logic [4:0]           inst_rs1,
   output logic [4:0]           inst_rs2,
   output logic [4:0]           inst_rd,
   output logic [31:0]          inst_pc,
   input  logic                 inst_ack,
   output logic                 reg_ready1,
   output logic                 reg_ready2,
   output logic [TAG_WIDTH-1:0] reg_tag1,
   output logic [TAG_WIDTH-1:0] reg_tag2,
   input  logic                 cdb_valid,
   input  logic [TAG_WIDTH-1:0] cdb_tag,
   input  logic                 commit_valid,
   input  logic [4:0]           commit_rd
`ifdef ISSUE_STALL_CNT_EN
   ,
   output logic [15:0]          stall_cycles
`endif
);

   localparam int PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
   localparam logic [PTR_W:0]     FULL_CNT = (PTR_W+1)'(IQ_DEPTH);
   localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]     CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [TAG_WIDTH-1:0] TAG_ONE = TAG_WIDTH'(1);

   typedef struct packed {
      logic [2:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
   } iq_entry_t;

   iq_entry_t              mem_q [IQ_DEPTH];
   iq_entry_t              mem_d [IQ_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]         count_q, count_d;
   logic [31:0]            busy_q, busy_d, done_q, done_d;
   logic [TAG_WIDTH-1:0]   tag_q [32];
   logic [TAG_WIDTH-1:0]   tag_d [32];
   logic [TAG_WIDTH-1:0]   issue_ptr_q, issue_ptr_d, commit_ptr_q, commit_ptr_d;

   iq_entry_t head;
   logic      empty, haz1, haz2, hazard, enq, deq;

   // A source whose value was broadcast but not yet committed cannot be read from either place.
   always_comb begin
      head        = mem_q[rd_ptr_q];
      empty       = (count_q == '0);
      haz1        = (head.rs1 != 5'd0) && busy_q[head.rs1] &&
                    (done_q[head.rs1] || (cdb_valid && (cdb_tag == tag_q[head.rs1])));
      haz2        = (head.rs2 != 5'd0) && busy_q[head.rs2] &&
                    (done_q[head.rs2] || (cdb_valid && (cdb_tag == tag_q[head.rs2])));
      hazard      = !empty && (haz1 || haz2);
      fetch_ready = (count_q != FULL_CNT);
      enq         = fetch_valid && fetch_ready;
      inst_valid  = !empty && !hazard;
      deq         = inst_valid && inst_ack;
      inst_op     = '0;
      inst_rs1    = '0;
      inst_rs2    = '0;
      inst_rd     = '0;
      inst_pc     = '0;
      reg_ready1  = 1'b1;
      reg_ready2  = 1'b1;
      reg_tag1    = '0;
      reg_tag2    = '0;
      if (!empty) begin
         inst_op    = head.op;
         inst_rs1   = head.rs1;
         inst_rs2   = head.rs2;
         inst_rd    = head.rd;
         inst_pc    = head.pc;
         reg_ready1 = !busy_q[head.rs1];
         reg_ready2 = !busy_q[head.rs2];
         reg_tag1   = busy_q[head.rs1] ? tag_q[head.rs1] : '0;
         reg_tag2   = busy_q[head.rs2] ? tag_q[head.rs2] : '0;
      end
   end

   // Later updates override earlier ones: CDB done-set, then commit-clear, then issue write.
   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      busy_d       = busy_q;
      done_d       = done_q;
      tag_d        = tag_q;
      issue_ptr_d  = issue_ptr_q;
      commit_ptr_d = commit_ptr_q;
      if (enq) begin
         mem_d[wr_ptr_q] = '{op: fetch_op, rs1: fetch_rs1, rs2: fetch_rs2, rd: fetch_rd, pc: fetch_pc};
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (deq) begin
         rd_ptr_d    = rd_ptr_q + PTR_ONE;
         issue_ptr_d = issue_ptr_q + TAG_ONE;
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (commit_valid) commit_ptr_d = commit_ptr_q + TAG_ONE;
      if (cdb_valid) begin
         for (int r = 1; r < 32; r++) begin
            if (busy_q[r] && (tag_q[r] == cdb_tag)) done_d[r] = 1'b1;
         end
      end
      if (commit_valid && busy_q[commit_rd] && (tag_q[commit_rd] == commit_ptr_q)) begin
         busy_d[commit_rd] = 1'b0;
         done_d[commit_rd] = 1'b0;
      end
      if (deq && (head.rd != 5'd0)) begin
         busy_d[head.rd] = 1'b1;
         done_d[head.rd] = 1'b0;
         tag_d[head.rd]  = issue_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         busy_q       <= '0;
         done_q       <= '0;
         issue_ptr_q  <= '0;
         commit_ptr_q <= '0;
         for (int r = 0; r < 32; r++) tag_q[r] <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         issue_ptr_q  <= issue_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         tag_q        <= tag_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef ISSUE_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (hazard && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_issue_frontend.sv
// Scoreboard bench for issue_frontend: queued instructions are predicted in order, RAT results by scenario.
module tb_issue_frontend;

   localparam int TW    = 4;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [2:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
   } entry_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          fetch_valid;
   logic [2:0]    fetch_op;
   logic [4:0]    fetch_rs1, fetch_rs2, fetch_rd;
   logic [31:0]   fetch_pc;
   logic          fetch_ready;
   logic          inst_valid;
   logic [2:0]    inst_op;
   logic [4:0]    inst_rs1, inst_rs2, inst_rd;
   logic [31:0]   inst_pc;
   logic          inst_ack;
   logic          reg_ready1, reg_ready2;
   logic [TW-1:0] reg_tag1, reg_tag2;
   logic          cdb_valid;
   logic [TW-1:0] cdb_tag;
   logic          commit_valid;
   logic [4:0]    commit_rd;
`ifdef ISSUE_STALL_CNT_EN
   logic [15:0]   stall_cycles;
`endif

   int     checks = 0;
   int     passes = 0;
   entry_t sb[$];

   issue_frontend #(.TAG_WIDTH(TW), .IQ_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .fetch_valid(fetch_valid), .fetch_op(fetch_op), .fetch_rs1(fetch_rs1),
      .fetch_rs2(fetch_rs2), .fetch_rd(fetch_rd), .fetch_pc(fetch_pc),
      .fetch_ready(fetch_ready),
      .inst_valid(inst_valid), .inst_op(inst_op), .inst_rs1(inst_rs1),
      .inst_rs2(inst_rs2), .inst_rd(inst_rd), .inst_pc(inst_pc),
      .inst_ack(inst_ack),
      .reg_ready1(reg_ready1), .reg_ready2(reg_ready2),
      .reg_tag1(reg_tag1), .reg_tag2(reg_tag2),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .commit_valid(commit_valid), .commit_rd(commit_rd)
`ifdef ISSUE_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) $display("[TB] FAIL %s: got %0h required %0h", tag, got, exp);
      else             passes++;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic entry_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] pc);
      entry_t e;
      e.op  = pc[4:2];
      e.rs1 = rs1;
      e.rs2 = rs2;
      e.rd  = rd;
      e.pc  = pc;
      return e;
   endfunction

   task automatic doReset();
      rst = 1'b1;
      tick();
      tick();
      rst          = 1'b0;
      fetch_valid  = 1'b0;
      inst_ack     = 1'b0;
      cdb_valid    = 1'b0;
      commit_valid = 1'b0;
      sb.delete();
      #1;
   endtask

   // One cycle of optional enqueue and/or head acknowledge, predicted from the bench's own queue.
   task automatic applyStimulus(input logic do_enq, input entry_t e, input logic do_ack);
      logic accept;
      fetch_valid = do_enq;
      fetch_op    = e.op;
      fetch_rs1   = e.rs1;
      fetch_rs2   = e.rs2;
      fetch_rd    = e.rd;
      fetch_pc    = e.pc;
      inst_ack    = do_ack;
      #1;
      accept = do_enq && (sb.size() < DEPTH);
      if (do_enq) checkOutput("fetch_ready", fetch_ready, sb.size() < DEPTH);
      if (sb.size() == 0) checkOutput("empty_inst_valid", inst_valid, 1'b0);
      if (do_ack && sb.size() > 0) begin
         checkOutput("ack_inst_valid", inst_valid, 1'b1);
         checkOutput("head_fields", {inst_op, inst_rs1, inst_rs2, inst_rd, inst_pc}, sb[0]);
      end
      tick();
      if (do_ack && sb.size() > 0) void'(sb.pop_front());
      if (accept) sb.push_back(e);
      fetch_valid = 1'b0;
      inst_ack    = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1; fetch_valid = 1'b0; fetch_op = '0; fetch_rs1 = '0; fetch_rs2 = '0;
      fetch_rd = '0; fetch_pc = '0; inst_ack = 1'b0; cdb_valid = 1'b0; cdb_tag = '0;
      commit_valid = 1'b0; commit_rd = '0;
      @(negedge clk);

      // Reset then idle
      doReset();
      checkOutput("rst_fetch_ready", fetch_ready, 1'b1);
      checkOutput("rst_inst_valid", inst_valid, 1'b0);
      checkOutput("rst_ready1", reg_ready1, 1'b1);
      checkOutput("rst_ready2", reg_ready2, 1'b1);
      checkOutput("rst_tags", {reg_tag1, reg_tag2}, '0);
      checkOutput("rst_inst_pc", inst_pc, 32'h0);
`ifdef ISSUE_STALL_CNT_EN
      checkOutput("rst_stall", stall_cycles, 16'h0);
`endif

      // Producer tag visible on a dependent head, cleared by commit
      doReset();
      applyStimulus(1'b1, mk(5'd0, 5'd0, 5'd3, 32'h200), 1'b0);
      checkOutput("latency_visible", inst_valid, 1'b1);
      applyStimulus(1'b0, mk(0, 0, 0, 0), 1'b1);
      applyStimulus(1'b1, mk(5'd3, 5'd0, 5'd0, 32'h204), 1'b0);
      checkOutput("dep_inst_valid", inst_valid, 1'b1);
      checkOutput("dep_ready1", reg_ready1, 1'b0);
      checkOutput("dep_tag1", reg_tag1, 4'd0);
      commit_valid = 1'b1; commit_rd = 5'd3;
      tick();
      commit_valid = 1'b0;
      #1;
      checkOutput("commit_ready1", reg_ready1, 1'b1);
      checkOutput("commit_tag1", reg_tag1, 4'd0);
      applyStimulus(1'b0, mk(0, 0, 0, 0), 1'b1);

      // Broadcast-but-uncommitted source stalls the head until commit
      doReset();
      applyStimulus(1'b1, mk(5'd0, 5'd0, 5'd3, 32'h300), 1'b0);
      applyStimulus(1'b0, mk(0, 0, 0, 0), 1'b1);
      applyStimulus(1'b1, mk(5'd0, 5'd3, 5'd0, 32'h304), 1'b0);
      checkOutput("pre_cdb_valid", inst_valid, 1'b1);
      checkOutput("pre_cdb_ready2", reg_ready2, 1'b0);
`ifdef ISSUE_STALL_CNT_EN
      checkOutput("pre_cdb_stall", stall_cycles, 16'd0);
`endif
      cdb_valid = 1'b1; cdb_tag = 4'd0;
      #1;
      checkOutput("cdb_same_cycle_stall", inst_valid, 1'b0);
      tick();
      cdb_valid = 1'b0;
      #1;
      checkOutput("done_stall", inst_valid, 1'b0);
      tick();
`ifdef ISSUE_STALL_CNT_EN
      checkOutput("stall_count2", stall_cycles, 16'd2);
`endif
      commit_valid = 1'b1; commit_rd = 5'd3;
      tick();
      commit_valid = 1'b0;
      #1;
      checkOutput("post_commit_valid", inst_valid, 1'b1);
      checkOutput("post_commit_ready2", reg_ready2, 1'b1);
`ifdef ISSUE_STALL_CNT_EN
      checkOutput("stall_count3", stall_cycles, 16'd3);
`endif
      applyStimulus(1'b0, mk(0, 0, 0, 0), 1'b1);

      // Fill the queue with no acks, then drain in order (including a refused enqueue while full)
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, mk(5'd1, 5'd2, 5'd0, 32'h100 + 32'(4 * i)), 1'b0);
      checkOutput("full_fetch_ready", fetch_ready, 1'b0);
      checkOutput("full_head_pc", inst_pc, 32'h100);
      applyStimulus(1'b1, mk(5'd1, 5'd1, 5'd0, 32'h110), 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, mk(0, 0, 0, 0), 1'b1);
      checkOutput("drained_valid", inst_valid, 1'b0);
      checkOutput("drained_ready", fetch_ready, 1'b1);

      // Simultaneous enqueue and dequeue keep occupancy
      applyStimulus(1'b1, mk(5'd4, 5'd0, 5'd0, 32'h140), 1'b0);
      applyStimulus(1'b1, mk(5'd0, 5'd4, 5'd0, 32'h144), 1'b1);
      applyStimulus(1'b0, mk(0, 0, 0, 0), 1'b1);
      checkOutput("bypass_empty", inst_valid, 1'b0);

      // WAW on r5: only the newest writer's commit frees it
      doReset();
      applyStimulus(1'b1, mk(5'd0, 5'd0, 5'd5, 32'h500), 1'b0);
      applyStimulus(1'b1, mk(5'd0, 5'd0, 5'd5, 32'h504), 1'b1);
      applyStimulus(1'b1, mk(5'd5, 5'd0, 5'd0, 32'h508), 1'b1);
      checkOutput("waw_ready1", reg_ready1, 1'b0);
      checkOutput("waw_tag1", reg_tag1, 4'd1);
      commit_valid = 1'b1; commit_rd = 5'd5;
      tick();
      #1;
      checkOutput("waw_old_commit_ready", reg_ready1, 1'b0);
      checkOutput("waw_old_commit_tag", reg_tag1, 4'd1);
      tick();
      commit_valid = 1'b0;
      #1;
      checkOutput("waw_new_commit_ready", reg_ready1, 1'b1);
      checkOutput("waw_new_commit_tag", reg_tag1, 4'd0);
      applyStimulus(1'b0, mk(0, 0, 0, 0), 1'b1);

      // rd=0 consumes a tag but leaves the RAT alone
      doReset();
      applyStimulus(1'b1, mk(5'd0, 5'd0, 5'd0, 32'h600), 1'b0);
      checkOutput("r0_ready1", reg_ready1, 1'b1);
      checkOutput("r0_tag1", reg_tag1, 4'd0);
      applyStimulus(1'b1, mk(5'd0, 5'd0, 5'd7, 32'h604), 1'b1);
      applyStimulus(1'b1, mk(5'd7, 5'd0, 5'd0, 32'h608), 1'b1);
      checkOutput("r0_ptr_advanced_tag", reg_tag1, 4'd1);
      checkOutput("r0_ptr_advanced_ready", reg_ready1, 1'b0);

      // Issue write beats a same-cycle commit-clear of the same register
      doReset();
      applyStimulus(1'b1, mk(5'd0, 5'd0, 5'd3, 32'h700), 1'b0);
      applyStimulus(1'b1, mk(5'd0, 5'd0, 5'd3, 32'h704), 1'b1);
      commit_valid = 1'b1; commit_rd = 5'd3;
      applyStimulus(1'b1, mk(5'd3, 5'd0, 5'd0, 32'h708), 1'b1);
      commit_valid = 1'b0;
      #1;
      checkOutput("collide_ready1", reg_ready1, 1'b0);
      checkOutput("collide_tag1", reg_tag1, 4'd1);

      // Reset mid-operation discards queue and RAT; inputs during reset are ignored
      doReset();
      applyStimulus(1'b1, mk(5'd0, 5'd0, 5'd9, 32'h800), 1'b0);
      applyStimulus(1'b1, mk(5'd0, 5'd0, 5'd0, 32'h804), 1'b1);
      applyStimulus(1'b1, mk(5'd0, 5'd0, 5'd0, 32'h808), 1'b0);
      rst = 1'b1;
      fetch_valid = 1'b1; fetch_pc = 32'h80C; inst_ack = 1'b1;
      tick();
      rst = 1'b0; fetch_valid = 1'b0; inst_ack = 1'b0;
      sb.delete();
      #1;
      checkOutput("midrst_inst_valid", inst_valid, 1'b0);
      checkOutput("midrst_fetch_ready", fetch_ready, 1'b1);
      applyStimulus(1'b1, mk(5'd9, 5'd0, 5'd0, 32'h810), 1'b0);
      checkOutput("midrst_ready1", reg_ready1, 1'b1);
      checkOutput("midrst_tag1", reg_tag1, 4'd0);
      applyStimulus(1'b0, mk(0, 0, 0, 0), 1'b1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
